// File: rtl/imem_boot_loader_pkg.sv
// Shared types and sizing for the instruction-memory boot loader.
// Loader FSM states plus default imem geometry and CPU run budget.
package imem_boot_loader_pkg;

  localparam int IMEM_ADDR_WIDTH = 8;
  localparam int INSTR_WIDTH     = 32;
  localparam int RUN_BUDGET      = 64;

  typedef enum logic [2:0] {
    CLEAR,
    LOAD,
    RELEASE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/imem_boot_loader_sat_counter.sv
// Saturating up-counter with enable, synchronous clear and async reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: zero-fills imem, streams a program in, then runs the CPU
// for a fixed cycle budget while counting stall and flush events.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = INSTR_WIDTH,
  parameter int MAX_CYCLES = RUN_BUDGET
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  load_last_i,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [DATA_WIDTH-1:0] imem_data_o,
  output logic                  cpu_rst_o,
  output logic                  cpu_start_o,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  done_o,
  output logic [ADDR_WIDTH:0]   words_o,
  output logic [31:0]           cycle_cnt_o,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [31:0] RUN_END = 32'(MAX_CYCLES - 1);

  state_t state;
  state_t next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic xfer;
  logic run;
  logic clr;

  assign xfer = (state == LOAD) && load_ready_o && load_valid_i;
  assign run  = (state == RUN);
  assign clr  = (state == CLEAR);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= CLEAR;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      CLEAR:   if (ptr == LAST_ADDR) next = LOAD;
      LOAD: begin
        if (xfer && (load_last_i || ptr == LAST_ADDR)) begin
          next = RELEASE;
        end
      end
      RELEASE: next = RUN;
      RUN:     if (cycle_cnt_o >= RUN_END) next = DONE;
      DONE:    next = DONE;
      default: next = CLEAR;
    endcase
  end

  // Control outputs follow the state being entered so they stay registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr          <= '0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_data_o  <= '0;
      words_o      <= '0;
      load_ready_o <= 1'b0;
      cpu_rst_o    <= 1'b1;
      cpu_start_o  <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      load_ready_o <= (next == LOAD);
      cpu_rst_o    <= !((next == RUN) || (next == DONE));
      cpu_start_o  <= (next == RUN);
      done_o       <= (next == DONE);
      imem_we_o    <= 1'b0;
      if (clr) begin
        imem_we_o   <= 1'b1;
        imem_addr_o <= ptr;
        imem_data_o <= '0;
        ptr         <= ptr + ADDR_WIDTH'(1);
      end else if (xfer) begin
        imem_we_o   <= 1'b1;
        imem_addr_o <= ptr;
        imem_data_o <= load_data_i;
        ptr         <= ptr + ADDR_WIDTH'(1);
        words_o     <= words_o + (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  sat_counter #(.WIDTH(32)) u_cycle (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (run),
    .clr   (clr),
    .count (cycle_cnt_o)
  );

  sat_counter #(.WIDTH(32)) u_stall (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (run && stall_i),
    .clr   (clr),
    .count (stall_cnt_o)
  );

  sat_counter #(.WIDTH(32)) u_flush (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (run && flush_i),
    .clr   (clr),
    .count (flush_cnt_o)
  );

endmodule
